// File: rtl/tdm_demux4.sv
// Four-slot TDM receiver: aligns on sof, routes slot k to y[k], presents a whole frame at once.
// Optional TDM_DEMUX4_STRICT_SOF_EN: when defined, a slot-0 beat without sof drops lock.
module tdm_demux4 #(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_valid,
  input  logic                  sof,
  output logic [4*DATA_W-1:0]   y,
  output logic                  frame_valid,
  output logic [1:0]            slot,
  output logic                  locked,
  output logic                  sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t              r_state;
  logic [1:0]          r_slot;
  logic [DATA_W-1:0]   r_stg [0:3];
  logic [4*DATA_W-1:0] r_y;
  logic                r_frame_valid;
  logic                r_sync_err;

  state_t              w_state_nxt;
  logic [1:0]          w_slot_nxt;
  logic                w_stg_we;
  logic [1:0]          w_stg_idx;
  logic                w_load_y;
  logic                w_err;

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_stg_we    = 1'b0;
    w_stg_idx   = 2'd0;
    w_load_y    = 1'b0;
    w_err       = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (sof) begin
            w_stg_we    = 1'b1;
            w_stg_idx   = 2'd0;
            w_slot_nxt  = 2'd1;
            w_state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (sof && (r_slot != 2'd0)) begin
            // Early sof: drop the partial frame and realign on this beat.
            w_err      = 1'b1;
            w_stg_we   = 1'b1;
            w_stg_idx  = 2'd0;
            w_slot_nxt = 2'd1;
          end
`ifdef TDM_DEMUX4_STRICT_SOF_EN
          else if (!sof && (r_slot == 2'd0)) begin
            w_err       = 1'b1;
            w_slot_nxt  = 2'd0;
            w_state_nxt = HUNT;
          end
`endif
          else begin
            w_stg_we   = 1'b1;
            w_stg_idx  = r_slot;
            w_slot_nxt = r_slot + 2'd1;
            w_load_y   = (r_slot == 2'd3);
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= HUNT;
      r_slot        <= 2'd0;
      r_y           <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      for (int i = 0; i < 4; i++) r_stg[i] <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_slot        <= w_slot_nxt;
      r_frame_valid <= w_load_y;
      r_sync_err    <= w_err;
      if (w_stg_we) r_stg[w_stg_idx] <= din;
      // Slot 3 goes straight from din so the frame appears one cycle after its last beat.
      if (w_load_y) r_y <= {din, r_stg[2], r_stg[1], r_stg[0]};
    end
  end

  assign y           = r_y;
  assign frame_valid = r_frame_valid;
  assign slot        = r_slot;
  assign locked      = (r_state == LOCK);
  assign sync_err    = r_sync_err;

endmodule
